// File: rtl/chain_meter_pkg.sv
// Shared types and default sizing for the chain latency meter.
package chain_meter_pkg;

  localparam int CNT_W_DEFAULT   = 16;
  localparam int TIMEOUT_DEFAULT = 1023;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/chain_lat_counter.sv
// Clearable up-counter; exposes count+1 and flags when count+1 reaches TIMEOUT.
module chain_lat_counter
  import chain_meter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count_plus1,
  output logic             hit
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign count_plus1 = count_q + CNT_W'(1);
  assign hit         = (count_plus1 == CNT_W'(TIMEOUT));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_plus1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/chain_latency_meter.sv
// Measures per-lane delay-chain latency by toggling a launch bit and timing the echo.
// Define CHAIN_LATENCY_STATS_EN to add lat_min/lat_max tracking of arrived results.
module chain_latency_meter
  import chain_meter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       lane_sel,
  output logic [7:0]       launch,
  input  logic [7:0]       chain_out,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] latency
`ifdef CHAIN_LATENCY_STATS_EN
  ,
  output logic [CNT_W-1:0] lat_min,
  output logic [CNT_W-1:0] lat_max
`endif
);

  state_e           state_q, state_d;
  logic [2:0]       lane_q, lane_d;
  logic             ref_q, ref_d;
  logic [7:0]       launch_q, launch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] latency_q, latency_d;

  logic             cnt_clear;
  logic             cnt_enable;
  logic [CNT_W-1:0] cnt_plus1;
  logic             cnt_hit;
  logic             arrived;
  logic             arrive_evt;

  chain_lat_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (cnt_clear),
    .enable      (cnt_enable),
    .count_plus1 (cnt_plus1),
    .hit         (cnt_hit)
  );

  assign arrived = (chain_out[lane_q] != ref_q);

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    ref_d      = ref_q;
    launch_d   = launch_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    latency_d  = latency_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    arrive_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          lane_d           = lane_sel;
          launch_d[lane_sel] = ~launch_q[lane_sel];
          ref_d            = chain_out[lane_sel];
          cnt_clear        = 1'b1;
          timeout_d        = 1'b0;
          busy_d           = 1'b1;
          state_d          = RUN;
        end
      end
      RUN: begin
        cnt_enable = 1'b1;
        // Arrival takes priority over a timeout landing on the same edge.
        if (arrived) begin
          latency_d  = cnt_plus1;
          done_d     = 1'b1;
          arrive_evt = 1'b1;
          state_d    = FIN;
        end else if (cnt_hit) begin
          latency_d = CNT_W'(TIMEOUT);
          timeout_d = 1'b1;
          state_d   = FIN;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      ref_q     <= 1'b0;
      launch_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      latency_q <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      ref_q     <= ref_d;
      launch_q  <= launch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      latency_q <= latency_d;
    end
  end

  assign launch  = launch_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign latency = latency_q;

`ifdef CHAIN_LATENCY_STATS_EN
  logic [CNT_W-1:0] lat_min_q, lat_min_d;
  logic [CNT_W-1:0] lat_max_q, lat_max_d;

  always_comb begin
    lat_min_d = lat_min_q;
    lat_max_d = lat_max_q;
    if (arrive_evt) begin
      if (cnt_plus1 < lat_min_q) lat_min_d = cnt_plus1;
      if (cnt_plus1 > lat_max_q) lat_max_d = cnt_plus1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_min_q <= '1;
      lat_max_q <= '0;
    end else begin
      lat_min_q <= lat_min_d;
      lat_max_q <= lat_max_d;
    end
  end

  assign lat_min = lat_min_q;
  assign lat_max = lat_max_q;
`else
  logic unused_arrive;
  assign unused_arrive = arrive_evt;
`endif

endmodule
